sci_tx: RTL and testbench

SCI_TX -- requirements
Module: sci_tx

---
 rtl/sci_pkg.sv | 34 +++
 rtl/sci_tx_fifo.sv | 51 +++++
 rtl/sci_tx.sv | 147 ++++++++++++++
 tb/tb_sci_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sci_pkg.sv
// sci_pkg: shared FSM encoding, frame constants and stream type for sci_tx.
// Build option: define SCI_TX_PARITY_EN to add an even-parity bit to each frame.
package sci_pkg;

   localparam int unsigned DATA_BITS       = 8;
   localparam int unsigned FRAME_BITS_BASE = 10;  // start + 8 data + stop
`ifdef SCI_TX_PARITY_EN
   localparam int unsigned PARITY_BITS     = 1;
`else
   localparam int unsigned PARITY_BITS     = 0;
`endif
   localparam int unsigned FRAME_BITS      = FRAME_BITS_BASE + PARITY_BITS;  // 10 or 11

   // A break frame holds the line low for one full frame length.
   localparam int unsigned BREAK_BITS      = FRAME_BITS;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef SCI_TX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } sci_state_e;

   // Byte stream sink: one byte per cycle with write high, no backpressure.
   typedef struct packed {
      logic [7:0] data;
      logic       write;
   } bytestream_t;

endpackage

// File: rtl/sci_tx_fifo.sv
// sci_tx_fifo: byte FIFO ahead of the shifter. Pointers carry one wrap bit so
// full and empty are told apart without a separate count. Callers guarantee
// pop only when not empty and push only when not full (or popping).
module sci_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk30,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] wr_ptr_d, rd_ptr_d;
   logic [7:0]  mem [DEPTH];

   assign wr_ptr_d = wr_ptr + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr + {{AW{1'b0}}, pop};

   // Pointer registers; full/empty are registered from the next pointers.
   always_ff @(posedge clk30) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_d;
         rd_ptr <= rd_ptr_d;
         empty  <= (wr_ptr_d == rd_ptr_d);
         full   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      end
   end

   // Storage write.
   always_ff @(posedge clk30) begin
      // NOTE: storage is not reset; the pointers alone define which slots are valid.
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sci_tx.sv
// sci_tx: serial transmitter with byte FIFO, break generation and overrun flag.
// FIFO_DEPTH must be a power of two in 2..16.
// Build option: SCI_TX_PARITY_EN inserts an even-parity bit between data and stop.
module sci_tx
   import sci_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk30,
   input  logic        reset,
   input  bytestream_t serial_in,
   input  logic        te,
   input  logic        sbk,
   input  logic [15:0] baud_div,
   output logic        txd,
   output logic        tdre,
   output logic        tc,
   output logic        overrun,
   input  logic        overrun_clr
);

   sci_state_e  state, next_state;
   logic [15:0] baud_cnt, baud_cnt_d;
   logic [15:0] div_q, div_d;
   logic [3:0]  bit_cnt, bit_cnt_d;
   logic [7:0]  shreg, shreg_d;
   logic        txd_q, txd_d;
   logic        bit_end, start_ok, pop, push, load_div;
   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;
`ifdef SCI_TX_PARITY_EN
   logic        par_q, par_d;
`endif

   sci_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk30 (clk30),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (serial_in.data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bit_end  = (state != IDLE) && (baud_cnt == 16'd0);
   assign start_ok = te && !sbk && !fifo_empty;
   // A write while full is accepted only if the same edge frees a slot.
   assign push     = serial_in.write && (!fifo_full || pop);

   // State register.
   always_ff @(posedge clk30) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic: frame sequencing, back-to-back starts, break repeats.
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      next_state = state;
      unique case (state)
         IDLE:   if (sbk) next_state = BREAK;
                 else if (start_ok) next_state = START;
         START:  if (bit_end) next_state = DATA;
`ifdef SCI_TX_PARITY_EN
         DATA:   if (bit_end && bit_cnt == 4'(DATA_BITS - 1)) next_state = PARITY;
         PARITY: if (bit_end) next_state = STOP;
`else
         DATA:   if (bit_end && bit_cnt == 4'(DATA_BITS - 1)) next_state = STOP;
`endif
         STOP:   if (bit_end) next_state = start_ok ? START : IDLE;
         BREAK:  if (bit_end && bit_cnt == 4'(BREAK_BITS)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output/datapath logic: pop, bit timing, shift data and next txd level.
   always_comb begin
      pop      = (next_state == START) && (state != START);
      load_div = ((state == IDLE) && (next_state != IDLE)) || pop;
      div_d    = load_div ? baud_div : div_q;

      if (next_state == IDLE)  baud_cnt_d = '0;
      else if (load_div)       baud_cnt_d = baud_div;
      else if (bit_end)        baud_cnt_d = div_q;
      else                     baud_cnt_d = baud_cnt - 16'd1;

      // Bit index within DATA or BREAK; a break frame restarts while sbk stays high.
      bit_cnt_d = bit_cnt;
      if (next_state != state) bit_cnt_d = '0;
      else if (bit_end) begin
         if (state == BREAK && bit_cnt == 4'(BREAK_BITS - 1) && sbk) bit_cnt_d = '0;
         else                                                         bit_cnt_d = bit_cnt + 4'd1;
      end

      shreg_d = shreg;
      if (pop)                            shreg_d = fifo_dout;
      else if (state == DATA && bit_end)  shreg_d = shreg >> 1;

`ifdef SCI_TX_PARITY_EN
      par_d = pop ? ^fifo_dout : par_q;
`endif

      case (next_state)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shreg_d[0];
`ifdef SCI_TX_PARITY_EN
         PARITY:  txd_d = par_q;
`endif
         BREAK:   txd_d = (bit_cnt_d == 4'(BREAK_BITS));
         default: txd_d = 1'b1;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk30) begin
      if (reset) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         div_q    <= '0;
         shreg    <= '0;
         txd_q    <= 1'b1;
         overrun  <= 1'b0;
`ifdef SCI_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         baud_cnt <= baud_cnt_d;
         bit_cnt  <= bit_cnt_d;
         div_q    <= div_d;
         shreg    <= shreg_d;
         txd_q    <= txd_d;
`ifdef SCI_TX_PARITY_EN
         par_q    <= par_d;
`endif
         // A dropped byte sets the flag even when a clear arrives the same cycle.
         if (serial_in.write && !push) overrun <= 1'b1;
         else if (overrun_clr)         overrun <= 1'b0;
      end
   end

   assign txd  = txd_q;
   // Both flags are formed from flops only (FIFO empty flag and state register).
   assign tdre = fifo_empty;
   assign tc   = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_sci_tx.sv
// tb_sci_tx: directed bench for sci_tx with a waveform-queue reference model.
// Build option: SCI_TX_PARITY_EN selects the parity frame expectations.
module tb_sci_tx;
   import sci_pkg::*;

   localparam int DEPTH = 4;
`ifdef SCI_TX_PARITY_EN
   localparam int BRK_LOW_BITS = 22;
`else
   localparam int BRK_LOW_BITS = 20;
`endif

   logic        clk30 = 1'b0;
   logic        reset;
   bytestream_t serial_in;
   logic        te, sbk, overrun_clr;
   logic [15:0] baud_div;
   logic        txd, tdre, tc, overrun;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   always #5 clk30 = ~clk30;

   sci_tx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk30       (clk30),
      .reset       (reset),
      .serial_in   (serial_in),
      .te          (te),
      .sbk         (sbk),
      .baud_div    (baud_div),
      .txd         (txd),
      .tdre        (tdre),
      .tc          (tc),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // The line is a queue of future per-cycle txd levels; whenever it runs dry
   // the transmitter is at a decision point (idle, end of frame, end of break).
   typedef enum int {C_IDLE, C_FRAME, C_BRK, C_BSTOP} mctx_e;

   logic [7:0] q[$];
   bit         wave[$];
   mctx_e      ctx       = C_IDLE;
   int         m_div     = 0;
   logic       m_txd     = 1'b1;
   logic       m_overrun = 1'b0;

   function automatic void add_cells(bit v, int n);
      for (int i = 0; i < n; i++) wave.push_back(v);
   endfunction

   function automatic void add_frame(logic [7:0] b, int cells);
      add_cells(1'b0, cells);
      for (int k = 0; k < 8; k++) add_cells(b[k], cells);
`ifdef SCI_TX_PARITY_EN
      add_cells(^b, cells);
`endif
      add_cells(1'b1, cells);
   endfunction

   always @(posedge clk30) begin
      if (reset) begin
         q.delete();
         wave.delete();
         ctx       = C_IDLE;
         m_overrun = 1'b0;
         m_txd     = 1'b1;
      end else begin
         if (wave.size() == 0) begin
            case (ctx)
               C_IDLE, C_FRAME: begin
                  if (ctx == C_IDLE && sbk) begin
                     m_div = int'(baud_div);
                     add_cells(1'b0, BRK_LOW_BITS / 2 * (m_div + 1));
                     ctx = C_BRK;
                  end else if (te && !sbk && q.size() > 0) begin
                     add_frame(q.pop_front(), int'(baud_div) + 1);
                     ctx = C_FRAME;
                  end else begin
                     ctx = C_IDLE;
                  end
               end
               C_BRK: begin
                  if (sbk) add_cells(1'b0, BRK_LOW_BITS / 2 * (m_div + 1));
                  else begin
                     add_cells(1'b1, m_div + 1);
                     ctx = C_BSTOP;
                  end
               end
               default: ctx = C_IDLE;
            endcase
         end
         if (serial_in.write && q.size() >= DEPTH) m_overrun = 1'b1;
         else begin
            if (serial_in.write) q.push_back(serial_in.data);
            if (overrun_clr) m_overrun = 1'b0;
         end
         m_txd = (wave.size() > 0) ? wave.pop_front() : 1'b1;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk30) begin
      if (cmp_en) begin
         check("model_txd", txd, m_txd);
         check("model_tdre", tdre, q.size() == 0);
         check("model_tc", tc, (ctx == C_IDLE) && (q.size() == 0));
         check("model_overrun", overrun, m_overrun);
      end
   end

   // Checks txd against a literal bit string, cells cycles per bit, starting now.
   task automatic check_frame(input string name, input string bits, input int cells);
      for (int i = 0; i < bits.len(); i++) begin
         for (int c = 0; c < cells; c++) begin
            check($sformatf("%s_bit%0d", name, i), txd, bits[i] == 8'h31);
            @(negedge clk30);
         end
      end
   endtask

   task automatic put(input logic [7:0] d);
      serial_in.data  = d;
      serial_in.write = 1'b1;
   endtask

`ifdef SCI_TX_PARITY_EN
   localparam string F_A5  = "01010010101";
   localparam string F_00  = "00000000001";
   localparam string F_FF  = "01111111101";
   localparam string F_55  = "01010101001";
   localparam string F_OVR = {"01000000011", "00100000011", "01100000001", "00010000011"};
`else
   localparam string F_A5  = "0101001011";
   localparam string F_00  = "0000000001";
   localparam string F_FF  = "0111111111";
   localparam string F_55  = "0101010101";
   localparam string F_OVR = {"0100000001", "0010000001", "0110000001", "0001000001"};
`endif

   initial begin
      reset       = 1'b1;
      serial_in   = '0;
      te          = 1'b0;
      sbk         = 1'b0;
      baud_div    = 16'd3;
      overrun_clr = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk30);
      check("rst_txd", txd, 1'b1);
      check("rst_tdre", tdre, 1'b1);
      check("rst_tc", tc, 1'b1);
      check("rst_overrun", overrun, 1'b0);
      cmp_en = 1'b1;
      #1 reset = 1'b0;

      // Single byte 0xA5, 4 cycles per bit.
      @(negedge clk30); #1;
      te = 1'b1; baud_div = 16'd3; put(8'hA5);
      @(negedge clk30);
      check("a5_txd_before_start", txd, 1'b1);
      check("a5_tdre_loaded", tdre, 1'b0);
      check("a5_tc_loaded", tc, 1'b0);
      #1 serial_in.write = 1'b0;
      @(negedge clk30);
      check_frame("a5", F_A5, 4);
      check("a5_tc_after", tc, 1'b1);
      check("a5_txd_after", txd, 1'b1);

      // Back-to-back 0x00, 0xFF at one cycle per bit.
      #1 baud_div = 16'd0; put(8'h00);
      @(negedge clk30); #1 put(8'hFF);
      @(negedge clk30);
      check("b2b_tdre_held", tdre, 1'b0);
      #1 serial_in.write = 1'b0;
      check_frame("b2b_00", F_00, 1);
      check("b2b_tdre_popped", tdre, 1'b1);
      check_frame("b2b_ff", F_FF, 1);
      check("b2b_tc_after", tc, 1'b1);

      // Overrun: five writes into a four-slot FIFO with te low.
      #1 te = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         put(8'(i));
         @(negedge clk30); #1;
      end
      serial_in.write = 1'b0;
      check("ovr_set", overrun, 1'b1);
      check("ovr_tdre", tdre, 1'b0);
      te = 1'b1;
      @(negedge clk30);
      check_frame("ovr_frames", F_OVR, 1);
      check("ovr_drained_tdre", tdre, 1'b1);
      check("ovr_drained_tc", tc, 1'b1);
      #1 overrun_clr = 1'b1;
      @(negedge clk30); #1 overrun_clr = 1'b0;
      check("ovr_cleared", overrun, 1'b0);

      // Set beats clear; a write while full with a same-cycle pop is kept.
      te = 1'b0;
      for (int i = 0; i < 4; i++) begin
         put(8'h10 + 8'(i));
         @(negedge clk30); #1;
      end
      put(8'h14); overrun_clr = 1'b1;
      @(negedge clk30);
      check("ovr_set_wins", overrun, 1'b1);
      #1 serial_in.write = 1'b0;
      @(negedge clk30); #1 overrun_clr = 1'b0;
      check("ovr_cleared2", overrun, 1'b0);
      te = 1'b1; put(8'h66);
      @(negedge clk30); #1 serial_in.write = 1'b0;
      check("full_pop_accepted", overrun, 1'b0);
      repeat (70) @(negedge clk30);
      check("full_pop_drained", tdre, 1'b1);

      // Break: sbk high for 15 bit times at two cycles per bit.
      #1 te = 1'b0; baud_div = 16'd1; sbk = 1'b1;
      fork
         begin
            repeat (30) @(negedge clk30);
            #1 sbk = 1'b0;
         end
      join_none
      @(negedge clk30);
      for (int i = 0; i < BRK_LOW_BITS * 2; i++) begin
         check($sformatf("brk_low%0d", i), txd, 1'b0);
         @(negedge clk30);
      end
      check_frame("brk_stop", "1", 2);
      check("brk_idle_tc", tc, 1'b1);
      check("brk_idle_txd", txd, 1'b1);

      // Reset in the 4th data bit of 0x3C with 0x99 still queued.
      #1 te = 1'b1; put(8'h3C);
      @(negedge clk30); #1 put(8'h99);
      @(negedge clk30); #1 serial_in.write = 1'b0;
      repeat (8) @(negedge clk30);
      check("rst_mid_d3", txd, 1'b1);
      check("rst_mid_tdre_before", tdre, 1'b0);
      #1 reset = 1'b1;
      @(negedge clk30);
      check("rst_mid_txd", txd, 1'b1);
      check("rst_mid_tdre", tdre, 1'b1);
      check("rst_mid_overrun", overrun, 1'b0);
      #1 reset = 1'b0; put(8'h55);
      @(negedge clk30); #1 serial_in.write = 1'b0;
      @(negedge clk30);
      check_frame("rst_55", F_55, 2);
      check("rst_55_tc", tc, 1'b1);

`ifdef SCI_TX_PARITY_EN
      // Parity frame for 0x07: odd count of ones gives parity bit 1.
      #1 baud_div = 16'd0; put(8'h07);
      @(negedge clk30); #1 serial_in.write = 1'b0;
      @(negedge clk30);
      check_frame("par_07", "01110000011", 1);
      check("par_07_tc", tc, 1'b1);
`endif

      repeat (4) @(negedge clk30);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
